binary_bram_streamer: RTL and testbench
=======================================

Name: binary_bram_streamer

Overview:
Read-side counterpart of the binary capture BRAM. Once a frame is captured and readable, it scans the 1-bit image in raster order through the BRAM read port. It re-emits the frame as a W-bit valid/ready pixel stream for display or debug readout. It owns the 1-cycle BRAM read latency and absorbs downstream backpressure with a 2-entry output buffer, so no pixel is lost or duplicated.

Parameters:
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
W, 8, output pixel width
ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), BRAM address width
FG_VALUE, {W{1'b1}}, output value for stored bit 1; stored bit 0 always outputs 0

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request to stream one frame
valid_to_read  in  1  BRAM holds a complete frame
bram_read_addr  out  ADDR_WIDTH  BRAM read address
bram_read_data  in  1  BRAM read data, valid 1 cycle after its address
y_valid  out  1  output pixel valid
y_ready  in  1  downstream ready
y_data  out  W  output pixel (0 or FG_VALUE)
busy  out  1  high from start acceptance until done or abort
done  out  1  1-cycle pulse after the last pixel handshake
aborted  out  1  1-cycle pulse when streaming is cut short by valid_to_read falling

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: y_valid=0, y_data=0, busy=0, done=0, aborted=0, bram_read_addr=0. Buffer is emptied, in-flight flag cleared, counters zeroed, FSM goes to IDLE.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE: if start && valid_to_read, go to STREAM and set busy=1 next cycle. start with valid_to_read low is ignored.
- start while busy is ignored.
- STREAM: issue a read when issue_cnt < N and (buf_count + inflight − pop) < 2.
  - N = IMG_WIDTH*IMG_HEIGHT.
  - pop = y_valid && y_ready.
  - Issuing drives bram_read_addr=issue_cnt, sets inflight for the next cycle and increments issue_cnt.
- Returned data: the cycle after an issue, bram_read_data is mapped to 0/FG_VALUE and pushed into the buffer.
- Buffer timing: y_valid is driven from the buffer head, which is registered. A push and a pop in the same cycle are both honoured.
- Latency: start accepted at cycle t → first read at t+1 → buffered at t+2 → y_valid=1 at t+2 (registered head). Throughput is 1 pixel/clk while y_ready=1.
- Backpressure: y_data must stay stable while y_valid && !y_ready. The buffer must never exceed 2 entries. The buffer is full exactly when 2 entries are held, or 1 is held and 1 is in flight with no pop.
- Last issue: when issue_cnt reaches N, go to DRAIN.
- DRAIN: wait until the buffer is empty and inflight=0, with the last handshake done. Then pulse done, clear busy and return to IDLE.
- Pixel count: exactly N handshakes per frame, in raster order, address = row*IMG_WIDTH+col.
- Abort: valid_to_read falling while busy (STREAM or DRAIN) flushes the buffer and drops y_valid the next cycle. It also pulses aborted, clears busy and returns to IDLE; done is not pulsed.
- Simultaneous events: if abort and the final handshake fall in the same cycle, the handshake completes and done wins; aborted is not pulsed.
- Reset mid-frame returns to the reset values above with no partial-frame residue. The next start restarts at address 0.
- Address counter width is ADDR_WIDTH. issue_cnt must not wrap; it saturates at N.

Optional Feature:
Macro STREAM_FRAME_MARKERS_EN.
- Defined: adds output ports y_sof (1) and y_eol (1), carried alongside each buffered pixel.
  - y_sof=1 on the pixel at address 0.
  - y_eol=1 on the pixel with col==IMG_WIDTH−1.
  - Both are valid only with y_valid and held stable under backpressure.
  - Reset value 0.
- Not defined: ports absent; the marker bits are not stored in the buffer.

Decomposition:
- Shared package pattern_pkg:
  - streamer_state_t enum {IDLE, STREAM, DRAIN}.
  - Pixel constants PIX_BG=0 and default FG.
  - The ADDR_WIDTH derivation as a function of IMG_WIDTH/IMG_HEIGHT, reused by the capture BRAM.
- One sub-module, stream_skid_fifo: 2-entry registered FIFO, parameterised data width. It exposes push, pop, count and head, and is used for {markers, pixel}.

Test Plan:
- Basic frame: 4x3 image, alternating bits; start with y_ready=1 → 12 handshakes in order 0..11, y_data ∈ {0,0xFF} matching the bits; first y_valid at t+2; done 1 cycle after the 12th handshake; busy low afterwards.
- Random backpressure: 4x3 frame, y_ready random 30% duty → same 12-pixel sequence, y_data stable while stalled, no duplicates/drops, buffer count ≤2 (assertion).
- Ignored starts: start with valid_to_read=0 → busy stays 0, no reads; second start mid-frame → no restart, exactly 12 pixels.
- Abort: drop valid_to_read after pixel 5 handshake → aborted pulse, y_valid=0 next cycle, no done; a new start streams from address 0.
- Reset mid-frame: rst high at pixel 7 for 1 cycle → all outputs 0 next cycle; the next frame is a full 12 pixels.
- Markers (STREAM_FRAME_MARKERS_EN): 4x3 frame → y_sof on pixel 0 only; y_eol on pixels 3, 7, 11; both held during stalls.

Source files
------------

// File: rtl/pattern_pkg.sv
// pattern_pkg - shared definitions for the binary capture / streaming path.
//
// Contents:
//   streamer_state_t  - FSM states of the BRAM streamer (IDLE, STREAM, DRAIN)
//   PIX_BG            - output value for a stored 0 bit
//   PIX_FG_DEFAULT    - default foreground value (all ones), sliced to W bits
//   calc_addr_width() - BRAM address width for an IMG_WIDTH x IMG_HEIGHT frame,
//                       shared with the capture BRAM so both sides agree
package pattern_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } streamer_state_t;

   localparam int          PIX_BG         = 0;
   localparam logic [31:0] PIX_FG_DEFAULT = 32'hFFFF_FFFF;

   // One address per pixel; never narrower than 1 bit.
   function automatic int calc_addr_width(input int img_w, input int img_h);
      int n;
      n = img_w * img_h;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo - 2-entry registered FIFO with a registered head.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   flush      - empties the FIFO (takes priority over push/pop)
//   push       - write push_data (ignored when full without a same-cycle pop)
//   push_data  - DW-bit entry
//   pop        - consume head (ignored when empty)
//   count      - number of held entries, 0..2
//   head       - oldest entry, straight from a register
module stream_skid_fifo #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [1:0]    count,
   output logic [DW-1:0] head
);

   logic [DW-1:0] e0_q, e0_d;
   logic [DW-1:0] e1_q, e1_d;
   logic [1:0]    count_q, count_d;
   logic          pop_ok, push_ok;

   always_comb begin
      e0_d    = e0_q;
      e1_d    = e1_q;
      count_d = count_q;
      pop_ok  = pop && (count_q != 2'd0);
      push_ok = push && ((count_q != 2'd2) || pop_ok);

      if (flush) begin
         count_d = 2'd0;
         e0_d    = '0;
         e1_d    = '0;
      end else begin
         case ({push_ok, pop_ok})
            2'b10: begin
               if (count_q == 2'd0) e0_d = push_data;
               else                 e1_d = push_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               e0_d    = e1_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // Simultaneous push/pop: occupancy unchanged, the queue shifts.
               if (count_q == 2'd1) begin
                  e0_d = push_data;
               end else begin
                  e0_d = e1_q;
                  e1_d = push_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e0_q    <= '0;
         e1_q    <= '0;
         count_q <= 2'd0;
      end else begin
         e0_q    <= e0_d;
         e1_q    <= e1_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign head  = e0_q;

endmodule

// File: rtl/binary_bram_streamer.sv
// binary_bram_streamer - scans a captured 1-bit frame out of BRAM in raster
// order and re-emits it as a W-bit valid/ready pixel stream (0 or FG_VALUE).
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - request one frame (honoured only in IDLE with valid_to_read)
//   valid_to_read   - BRAM holds a complete frame; falling while busy aborts
//   bram_read_addr  - BRAM read address (data returns one cycle later)
//   bram_read_data  - 1-bit BRAM read data
//   y_valid/y_ready/y_data - output pixel stream
//   y_sof, y_eol    - frame/line markers (only with STREAM_FRAME_MARKERS_EN)
//   busy            - frame in progress
//   done            - pulse after the last pixel handshake
//   aborted         - pulse when valid_to_read drops mid-frame
//
// Optional feature macro: STREAM_FRAME_MARKERS_EN (adds y_sof / y_eol).
module binary_bram_streamer
   import pattern_pkg::*;
#(
   parameter int            IMG_WIDTH  = 640,
   parameter int            IMG_HEIGHT = 480,
   parameter int            W          = 8,
   parameter int            ADDR_WIDTH = calc_addr_width(IMG_WIDTH, IMG_HEIGHT),
   parameter logic [W-1:0]  FG_VALUE   = PIX_FG_DEFAULT[W-1:0]
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  valid_to_read,
   output logic [ADDR_WIDTH-1:0] bram_read_addr,
   input  logic                  bram_read_data,
   output logic                  y_valid,
   input  logic                  y_ready,
   output logic [W-1:0]          y_data,
`ifdef STREAM_FRAME_MARKERS_EN
   output logic                  y_sof,
   output logic                  y_eol,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  aborted
);

   localparam int N_PIX = IMG_WIDTH * IMG_HEIGHT;
   // One extra bit so the counter can hold N itself even when N is a power of 2.
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] N_LAST = CW'(N_PIX);
`ifdef STREAM_FRAME_MARKERS_EN
   localparam int DW = W + 2;
`else
   localparam int DW = W;
`endif

   streamer_state_t state_q, state_d;
   logic [CW-1:0]   issue_cnt_q, issue_cnt_d;
   logic            inflight_q, inflight_d;
   logic            done_q, done_d;
   logic            aborted_q, aborted_d;

   logic            pop, issue, flush, abort_evt, last_hs;
   logic [2:0]      occ;
   logic [1:0]      fifo_count;
   logic [DW-1:0]   fifo_din, fifo_head;
   logic [W-1:0]    pix;

   assign y_valid = (fifo_count != 2'd0);
   assign pop     = y_valid && y_ready;
   // Occupancy the buffer will have next cycle before any new read returns.
   assign occ     = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign pix     = bram_read_data ? FG_VALUE : W'(PIX_BG);

   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      inflight_d  = 1'b0;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
      issue       = 1'b0;
      flush       = 1'b0;
      abort_evt   = (state_q != IDLE) && !valid_to_read;
      last_hs     = (state_q == DRAIN) && pop && (fifo_count == 2'd1) && !inflight_q;

      case (state_q)
         IDLE: begin
            issue_cnt_d = '0;
            if (start && valid_to_read) state_d = STREAM;
         end
         STREAM: begin
            if ((issue_cnt_q < N_LAST) && (occ < 3'd2)) begin
               issue       = 1'b1;
               inflight_d  = 1'b1;
               issue_cnt_d = issue_cnt_q + CW'(1);
               if (issue_cnt_d == N_LAST) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_hs) begin
               done_d      = 1'b1;
               issue_cnt_d = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A final handshake in the same cycle as the abort completes the frame.
      if (abort_evt && !last_hs) begin
         state_d     = IDLE;
         flush       = 1'b1;
         aborted_d   = 1'b1;
         inflight_d  = 1'b0;
         issue_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         issue_cnt_q <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         inflight_q  <= inflight_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

`ifdef STREAM_FRAME_MARKERS_EN
   localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_WIDTH - 1);

   // Marker bits are computed at issue time and travel with the in-flight read.
   logic [ADDR_WIDTH-1:0] col_q, col_d;
   logic                  sof_q, sof_d;
   logic                  eol_q, eol_d;

   always_comb begin
      col_d = col_q;
      sof_d = sof_q;
      eol_d = eol_q;
      if (issue) begin
         sof_d = (issue_cnt_q == '0);
         eol_d = (col_q == COL_LAST);
         col_d = (col_q == COL_LAST) ? '0 : col_q + ADDR_WIDTH'(1);
      end
      if (state_q == IDLE) col_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         sof_q <= 1'b0;
         eol_q <= 1'b0;
      end else begin
         col_q <= col_d;
         sof_q <= sof_d;
         eol_q <= eol_d;
      end
   end

   assign fifo_din = {eol_q, sof_q, pix};
   assign y_sof    = fifo_head[W];
   assign y_eol    = fifo_head[W+1];
`else
   assign fifo_din = pix;
`endif

   stream_skid_fifo #(
      .DW (DW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (inflight_q && !flush),
      .push_data (fifo_din),
      .pop       (pop),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign y_data         = fifo_head[W-1:0];
   assign bram_read_addr = issue_cnt_q[ADDR_WIDTH-1:0];
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign aborted        = aborted_q;

endmodule

// File: tb/tb_binary_bram_streamer.sv
module tb_binary_bram_streamer;

   localparam int IW = 4;
   localparam int IH = 3;
   localparam int NP = IW * IH;
   localparam int W  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst, start, valid_to_read, bram_read_data, y_ready;
   logic [AW-1:0] bram_read_addr;
   logic          y_valid, busy, done, aborted;
   logic [W-1:0]  y_data;
`ifdef STREAM_FRAME_MARKERS_EN
   logic          y_sof, y_eol;
`endif

   always #5 clk = ~clk;

   binary_bram_streamer #(
      .IMG_WIDTH  (IW),
      .IMG_HEIGHT (IH),
      .W          (W),
      .ADDR_WIDTH (AW),
      .FG_VALUE   (8'hFF)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .valid_to_read  (valid_to_read),
      .bram_read_addr (bram_read_addr),
      .bram_read_data (bram_read_data),
      .y_valid        (y_valid),
      .y_ready        (y_ready),
      .y_data         (y_data),
`ifdef STREAM_FRAME_MARKERS_EN
      .y_sof          (y_sof),
      .y_eol          (y_eol),
`endif
      .busy           (busy),
      .done           (done),
      .aborted        (aborted)
   );

   // BRAM model: one-cycle registered read.
   logic mem [0:NP-1];
   always @(posedge clk)
      bram_read_data <= (int'(bram_read_addr) < NP) ? mem[bram_read_addr] : 1'b0;

   typedef struct packed {
      logic [W-1:0] data;
      logic         sof;
      logic         eol;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   hs_cnt   = 0;
   int   last_hs_edge = -1;
   int   done_cnt = 0;
   int   abort_cnt = 0;
   int   sof_cnt  = 0;
   int   eol_cnt  = 0;
   bit   chk_stable = 1'b0;
   bit   ready_rand = 1'b0;
   bit   ovf_seen   = 1'b0;
   logic         stall_prev = 1'b0;
   logic [W-1:0] prev_data  = '0;
   logic         prev_sof   = 1'b0;
   logic         prev_eol   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Edge counter: after edge k (and before edge k+1), cyc == k.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Downstream ready: always 1, or ~30% duty when ready_rand is set.
   initial begin
      y_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         y_ready = ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
      end
   end

   // Monitor: samples at negedge; a valid&&ready seen here completes at the next edge.
   initial forever begin
      @(negedge clk);
      if (y_valid && y_ready) begin
         hs_cnt++;
         last_hs_edge = cyc + 1;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pixel: got data 0x%0h, expected no pixel", y_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("pixel_data", 32'(y_data), 32'(mon_e.data));
`ifdef STREAM_FRAME_MARKERS_EN
            check("pixel_sof", 32'(y_sof), 32'(mon_e.sof));
            check("pixel_eol", 32'(y_eol), 32'(mon_e.eol));
            if (y_sof) sof_cnt++;
            if (y_eol) eol_cnt++;
`endif
            $display("hs %0d: cycle %0d data=0x%02h", hs_cnt, cyc + 1, y_data);
         end
      end
      if (chk_stable && stall_prev) begin
         check("stall_valid", 32'(y_valid), 32'd1);
         check("stall_data", 32'(y_data), 32'(prev_data));
`ifdef STREAM_FRAME_MARKERS_EN
         check("stall_sof", 32'(y_sof), 32'(prev_sof));
         check("stall_eol", 32'(y_eol), 32'(prev_eol));
`endif
      end
      stall_prev = y_valid && !y_ready;
      prev_data  = y_data;
`ifdef STREAM_FRAME_MARKERS_EN
      prev_sof   = y_sof;
      prev_eol   = y_eol;
`endif
      if (done) begin
         done_cnt++;
         check("done_after_last_hs", 32'(cyc), 32'(last_hs_edge));
      end
      if (aborted) abort_cnt++;
      if (dut.u_fifo.count_q > 2'd2) ovf_seen = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input logic [NP-1:0] pat);
      exp_t e;
      for (int i = 0; i < NP; i++) begin
         mem[i] = pat[i];
         e.data = pat[i] ? 8'hFF : 8'h00;
         e.sof  = (i == 0);
         e.eol  = ((i % IW) == IW - 1);
         exp_q.push_back(e);
      end
      hs_cnt = 0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         tick();
         if (done) seen = 1'b1;
      end
      check({name, "_done_seen"}, 32'(seen), 32'd1);
      check({name, "_busy_at_done"}, 32'(busy), 32'd0);
      check({name, "_pixel_count"}, 32'(hs_cnt), 32'(NP));
      check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_hs(input string name, input int n, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         tick();
         if (hs_cnt >= n) seen = 1'b1;
      end
      check({name, "_hs_reached"}, 32'(seen), 32'd1);
   endtask

   int d0, a0;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      valid_to_read = 1'b0;
      for (int i = 0; i < NP; i++) mem[i] = 1'b0;
      tick();
      tick();
      check("rst_y_valid", 32'(y_valid), 32'd0);
      check("rst_y_data", 32'(y_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_aborted", 32'(aborted), 32'd0);
      check("rst_addr", 32'(bram_read_addr), 32'd0);
      rst = 1'b0;
      tick();

      // Basic frame, alternating bits, y_ready held high.
      valid_to_read = 1'b1;
      start_frame(12'hAAA);
      check("basic_busy_after_accept", 32'(busy), 32'd1);
      check("basic_valid_t0", 32'(y_valid), 32'd0);
      tick();
      check("basic_valid_t1", 32'(y_valid), 32'd0);
      tick();
      check("basic_valid_t2", 32'(y_valid), 32'd1);
      wait_done("basic", 100);
      tick();
      check("basic_done_pulse_len", 32'(done), 32'd0);
      check("basic_busy_after", 32'(busy), 32'd0);

      // Random backpressure with stall-stability checks.
      sof_cnt = 0;
      eol_cnt = 0;
      ready_rand = 1'b1;
      chk_stable = 1'b1;
      start_frame(12'h3C5);
      wait_done("bp", 400);
      ready_rand = 1'b0;
      chk_stable = 1'b0;
`ifdef STREAM_FRAME_MARKERS_EN
      check("bp_sof_count", 32'(sof_cnt), 32'd1);
      check("bp_eol_count", 32'(eol_cnt), 32'd3);
`endif
      tick();
      tick();

      // Start with valid_to_read low is ignored.
      valid_to_read = 1'b0;
      hs_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("ign_busy", 32'(busy), 32'd0);
      check("ign_valid", 32'(y_valid), 32'd0);
      check("ign_addr", 32'(bram_read_addr), 32'd0);
      check("ign_pixels", 32'(hs_cnt), 32'd0);
      valid_to_read = 1'b1;
      tick();

      // Second start mid-frame does not restart.
      d0 = done_cnt;
      start_frame(12'h5A6);
      wait_hs("restart", 4, 50);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("restart", 100);
      tick();
      check("restart_done_once", 32'(done_cnt - d0), 32'd1);

      // Abort after pixel 5 handshake.
      d0 = done_cnt;
      a0 = abort_cnt;
      start_frame(12'hF0F);
      wait_hs("abort", 6, 50);
      valid_to_read = 1'b0;
      tick();
      check("abort_pulse", 32'(aborted), 32'd1);
      check("abort_valid_drop", 32'(y_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_no_done", 32'(done), 32'd0);
      exp_q.delete();
      tick();
      check("abort_pulse_len", 32'(aborted), 32'd0);
      check("abort_valid_stays_low", 32'(y_valid), 32'd0);
      check("abort_count", 32'(abort_cnt - a0), 32'd1);
      check("abort_done_count", 32'(done_cnt - d0), 32'd0);
      valid_to_read = 1'b1;
      tick();
      start_frame(12'h69C);
      wait_done("post_abort", 100);
      tick();

      // Reset mid-frame at pixel 7.
      start_frame(12'h123);
      wait_hs("reset", 7, 50);
      rst = 1'b1;
      tick();
      check("mrst_y_valid", 32'(y_valid), 32'd0);
      check("mrst_y_data", 32'(y_data), 32'd0);
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_done", 32'(done), 32'd0);
      check("mrst_aborted", 32'(aborted), 32'd0);
      check("mrst_addr", 32'(bram_read_addr), 32'd0);
      rst = 1'b0;
      exp_q.delete();
      tick();
      start_frame(12'hE71);
      wait_done("post_reset", 100);
      tick();

      check("fifo_never_over_2", 32'(ovf_seen), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
